stage1_sequencer: RTL and testbench

Frame-level controller for the three per-leg `stage1` L/M/N datapaths (BETA = 90, 210, 330). It accepts one platform-pose frame of three 9-bit leg vectors and holds them stable on the leg inputs for the whole computation. It launches all three legs with a single-cycle `validIn` pulse, collects each leg's `validOut` independently, and emits one aligned result frame to the angle-solve stage. It also enforces a minimum launch period, detects hung legs with a watchdog, and counts frames dropped while busy.

---
 rtl/stage1_sequencer_pkg.sv | 32 +++
 rtl/leg_result_capture.sv | 58 +++++
 rtl/stage1_sequencer.sv | 133 +++++++++++++
 tb/tb_stage1_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage1_sequencer_pkg.sv
// ============================================================================
// Module      : stage1_sequencer_pkg
// Description : Shared widths, FSM encoding and slice helper for the sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package stage1_sequencer_pkg;

   localparam int NUM_LEGS = 3;
   localparam int VEC_W    = 9;
   localparam int L_W      = 16;
   localparam int MN_W     = 15;
   localparam int CNT_W    = 16;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LAUNCH  = 3'd1,
      S_WAIT    = 3'd2,
      S_EMIT    = 3'd3,
      S_HOLDOFF = 3'd4,
      S_FAULT   = 3'd5
   } state_t;

   // Low bit index of leg `leg` inside a packed per-leg bus.
   function automatic int slice_lo(input int leg, input int width);
      return leg * width;
   endfunction

endpackage

`default_nettype wire

// File: rtl/leg_result_capture.sv
// ============================================================================
// Module      : leg_result_capture
// Description : Per-leg done flag and L/M/N capture; first done wins per frame.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module leg_result_capture
   import stage1_sequencer_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            clear,
   input  logic            enable,
   input  logic            done,
   input  logic [L_W-1:0]  l_in,
   input  logic [MN_W-1:0] m_in,
   input  logic [MN_W-1:0] n_in,
   output logic            got_next,
   output logic [L_W-1:0]  l_next,
   output logic [MN_W-1:0] m_next,
   output logic [MN_W-1:0] n_next
);

   logic            got;
   logic [L_W-1:0]  l_q;
   logic [MN_W-1:0] m_q;
   logic [MN_W-1:0] n_q;
   logic            take;

   assign take = enable && done && !got;

   // Next-state values are exported so the parent can emit in the same edge
   // that the last leg lands.
   always_comb begin
      got_next = clear ? 1'b0 : (got | take);
      l_next   = take ? l_in : l_q;
      m_next   = take ? m_in : m_q;
      n_next   = take ? n_in : n_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         got <= 1'b0;
         l_q <= '0;
         m_q <= '0;
         n_q <= '0;
      end else begin
         got <= got_next;
         l_q <= l_next;
         m_q <= m_next;
         n_q <= n_next;
      end
   end

endmodule

`default_nettype wire

// File: rtl/stage1_sequencer.sv
// ============================================================================
// Module      : stage1_sequencer
// Description : Frame controller launching three stage1 legs and aligning results.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module stage1_sequencer
   import stage1_sequencer_pkg::*;
#(
   parameter int TIMEOUT    = 15,
   parameter int MIN_PERIOD = 0
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       frameValid,
   output logic                       frameReady,
   input  logic [NUM_LEGS*VEC_W-1:0]  lxIn,
   input  logic [NUM_LEGS*VEC_W-1:0]  lyIn,
   input  logic [NUM_LEGS*VEC_W-1:0]  lzIn,
   output logic [NUM_LEGS*VEC_W-1:0]  legLx,
   output logic [NUM_LEGS*VEC_W-1:0]  legLy,
   output logic [NUM_LEGS*VEC_W-1:0]  legLz,
   output logic [NUM_LEGS-1:0]        legValid,
   input  logic [NUM_LEGS-1:0]        legDone,
   input  logic [NUM_LEGS*L_W-1:0]    legL,
   input  logic [NUM_LEGS*MN_W-1:0]   legM,
   input  logic [NUM_LEGS*MN_W-1:0]   legN,
   output logic [NUM_LEGS*L_W-1:0]    L,
   output logic [NUM_LEGS*MN_W-1:0]   M,
   output logic [NUM_LEGS*MN_W-1:0]   N,
   output logic                       validOut,
   output logic                       fault,
   output logic [7:0]                 dropCount
);

   state_t                     state;
   logic [CNT_W-1:0]           cnt;
   logic [NUM_LEGS-1:0]        got_next;
   logic [NUM_LEGS*L_W-1:0]    l_next;
   logic [NUM_LEGS*MN_W-1:0]   m_next;
   logic [NUM_LEGS*MN_W-1:0]   n_next;

   assign frameReady = (state == S_IDLE);

   generate
      for (genvar k = 0; k < NUM_LEGS; k++) begin : g_leg
         leg_result_capture u_capture (
            .clock    (clock),
            .reset    (reset),
            .clear    (state == S_LAUNCH),
            .enable   (state == S_WAIT),
            .done     (legDone[k]),
            .l_in     (legL[slice_lo(k, L_W) +: L_W]),
            .m_in     (legM[slice_lo(k, MN_W) +: MN_W]),
            .n_in     (legN[slice_lo(k, MN_W) +: MN_W]),
            .got_next (got_next[k]),
            .l_next   (l_next[slice_lo(k, L_W) +: L_W]),
            .m_next   (m_next[slice_lo(k, MN_W) +: MN_W]),
            .n_next   (n_next[slice_lo(k, MN_W) +: MN_W])
         );
      end
   endgenerate

   // cnt restarts at the first WAIT cycle, so the launch cycle sits at cnt = -1;
   // it serves both as watchdog and as launch-period timer.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         legLx     <= '0;
         legLy     <= '0;
         legLz     <= '0;
         legValid  <= '0;
         validOut  <= 1'b0;
         fault     <= 1'b0;
         L         <= '0;
         M         <= '0;
         N         <= '0;
         dropCount <= '0;
      end else begin
         legValid <= '0;
         validOut <= 1'b0;
         if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
         if (frameValid && !frameReady && dropCount != 8'hFF) dropCount <= dropCount + 8'd1;

         case (state)
            S_IDLE: begin
               if (frameValid) begin
                  legLx    <= lxIn;
                  legLy    <= lyIn;
                  legLz    <= lzIn;
                  legValid <= '1;
                  state    <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               cnt   <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (&got_next) begin
                  L        <= l_next;
                  M        <= m_next;
                  N        <= n_next;
                  validOut <= 1'b1;
                  state    <= S_EMIT;
               end else if (int'(cnt) + 1 >= TIMEOUT) begin
                  fault <= 1'b1;
                  state <= S_FAULT;
               end
            end
            S_EMIT: begin
               // IDLE after this edge lets the next launch land at cnt+3 past launch.
               if (MIN_PERIOD > int'(cnt) + 3) state <= S_HOLDOFF;
               else                            state <= S_IDLE;
            end
            S_HOLDOFF: begin
               if (int'(cnt) + 3 >= MIN_PERIOD) state <= S_IDLE;
            end
            S_FAULT: begin
               state <= S_FAULT;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_stage1_sequencer.sv
// ============================================================================
// Module      : tb_stage1_sequencer
// Description : Two sequencers (MIN_PERIOD 0 and 20) against a timestamp model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_stage1_sequencer;

   localparam int TOUT = 15;

   logic        clock = 1'b0;
   logic        reset;
   logic        frameValid;
   logic [26:0] lxIn, lyIn, lzIn;

   logic        frameReady [2];
   logic [26:0] legLx [2], legLy [2], legLz [2];
   logic [2:0]  legValid [2];
   logic [2:0]  legDone [2];
   logic [47:0] legL [2], L [2];
   logic [44:0] legM [2], legN [2], M [2], N [2];
   logic        validOut [2], fault [2];
   logic [7:0]  dropCount [2];

   int n_total = 0, n_pass = 0, cyc = 0;

   always #5 clock = ~clock;

   stage1_sequencer #(.TIMEOUT(TOUT), .MIN_PERIOD(0)) dut0 (
      .clock(clock), .reset(reset), .frameValid(frameValid), .frameReady(frameReady[0]),
      .lxIn(lxIn), .lyIn(lyIn), .lzIn(lzIn),
      .legLx(legLx[0]), .legLy(legLy[0]), .legLz(legLz[0]),
      .legValid(legValid[0]), .legDone(legDone[0]),
      .legL(legL[0]), .legM(legM[0]), .legN(legN[0]),
      .L(L[0]), .M(M[0]), .N(N[0]),
      .validOut(validOut[0]), .fault(fault[0]), .dropCount(dropCount[0]));

   stage1_sequencer #(.TIMEOUT(TOUT), .MIN_PERIOD(20)) dut1 (
      .clock(clock), .reset(reset), .frameValid(frameValid), .frameReady(frameReady[1]),
      .lxIn(lxIn), .lyIn(lyIn), .lzIn(lzIn),
      .legLx(legLx[1]), .legLy(legLy[1]), .legLz(legLz[1]),
      .legValid(legValid[1]), .legDone(legDone[1]),
      .legL(legL[1]), .legM(legM[1]), .legN(legN[1]),
      .L(L[1]), .M(M[1]), .N(N[1]),
      .validOut(validOut[1]), .fault(fault[1]), .dropCount(dropCount[1]));

   function automatic int minp(input int i);
      return (i == 0) ? 0 : 20;
   endfunction

   // Stand-in stage1 arithmetic: L is the squared leg length minus 13775.
   function automatic logic [15:0] fL(input logic signed [8:0] x, y, z);
      int s;
      s = int'(x) * int'(x) + int'(y) * int'(y) + int'(z) * int'(z) - 13775;
      return s[15:0];
   endfunction
   function automatic logic [14:0] fM(input logic signed [8:0] x, y, z);
      int s;
      s = int'(x) * int'(y) + 3 * int'(z);
      return s[14:0];
   endfunction
   function automatic logic [14:0] fN(input logic signed [8:0] x, y, z);
      int s;
      s = int'(y) * int'(z) - int'(x);
      return s[14:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- behavioural reference model (timestamps per frame) ----
   logic        mr [2], mfault [2], mvo [2], inframe [2];
   logic [2:0]  mlv [2];
   logic [7:0]  mdrop [2];
   logic [26:0] mlx [2], mly [2], mlz [2];
   logic [47:0] mL [2];
   logic [44:0] mM [2], mN [2];
   logic [15:0] capL [2][3];
   logic [14:0] capM [2][3], capN [2][3];
   bit          got [2][3];
   int          launch_at [2], done_at [2];

   always @(posedge clock) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            mr[i] = 1; mfault[i] = 0; mvo[i] = 0; inframe[i] = 0; mlv[i] = 0; mdrop[i] = 0;
            mlx[i] = 0; mly[i] = 0; mlz[i] = 0; mL[i] = 0; mM[i] = 0; mN[i] = 0;
            done_at[i] = -1; launch_at[i] = 0;
         end else begin
            bit acc;
            int rdy_at;
            acc = mr[i] && frameValid;
            if (frameValid && !mr[i] && mdrop[i] != 8'd255) mdrop[i] = mdrop[i] + 8'd1;
            mvo[i] = 0;
            mlv[i] = acc ? 3'b111 : 3'b000;
            if (inframe[i] && !mfault[i] && done_at[i] < 0 && cyc > launch_at[i]) begin
               for (int k = 0; k < 3; k++) begin
                  if (legDone[i][k] && !got[i][k]) begin
                     got[i][k] = 1;
                     capL[i][k] = legL[i][16*k +: 16];
                     capM[i][k] = legM[i][15*k +: 15];
                     capN[i][k] = legN[i][15*k +: 15];
                  end
               end
               if (got[i][0] && got[i][1] && got[i][2]) begin
                  done_at[i] = cyc;
                  mvo[i] = 1;
                  mL[i] = {capL[i][2], capL[i][1], capL[i][0]};
                  mM[i] = {capM[i][2], capM[i][1], capM[i][0]};
                  mN[i] = {capN[i][2], capN[i][1], capN[i][0]};
               end else if (cyc - launch_at[i] >= TOUT) begin
                  mfault[i] = 1;
               end
            end
            rdy_at = done_at[i] + 2;
            if (launch_at[i] + minp(i) - 1 > rdy_at) rdy_at = launch_at[i] + minp(i) - 1;
            if (acc) begin
               mlx[i] = lxIn; mly[i] = lyIn; mlz[i] = lzIn;
               launch_at[i] = cyc + 1; done_at[i] = -1; inframe[i] = 1; mr[i] = 0;
               for (int k = 0; k < 3; k++) got[i][k] = 0;
            end else if (mfault[i]) begin
               mr[i] = 0;
            end else if (inframe[i] && done_at[i] >= 0 && cyc + 1 >= rdy_at) begin
               mr[i] = 1; inframe[i] = 0;
            end
         end
      end
      cyc = cyc + 1;
   end

   always @(negedge clock) begin
      if (cyc > 1) begin
         for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d_frameReady", i), frameReady[i], mr[i]);
            check($sformatf("d%0d_legValid", i), legValid[i], mlv[i]);
            check($sformatf("d%0d_validOut", i), validOut[i], mvo[i]);
            check($sformatf("d%0d_fault", i), fault[i], mfault[i]);
            check($sformatf("d%0d_dropCount", i), dropCount[i], mdrop[i]);
            check($sformatf("d%0d_legLxyz", i), {legLx[i], legLy[i]}, {mlx[i], mly[i]});
            check($sformatf("d%0d_legLz", i), legLz[i], mlz[i]);
            check($sformatf("d%0d_L", i), L[i], mL[i]);
            check($sformatf("d%0d_MN", i), {M[i][29:0], N[i][29:0]}, {mM[i][29:0], mN[i][29:0]});
            check($sformatf("d%0d_MNhi", i), {M[i][44:30], N[i][44:30]}, {mM[i][44:30], mN[i][44:30]});
         end
      end
   end

   // ---------------- stage1 leg responders --------------------------------
   logic signed [8:0] sx [2][3], sy [2][3], sz [2][3];
   int  due [2][3], dupdue [2][3];
   int  lat [3];
   bit  never [3];
   bit  dup0, rand_mode;

   task automatic respond();
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 3; k++) begin
            logic fire, fdup, spur;
            if (legValid[i][k] === 1'b1) begin
               int lt;
               sx[i][k] = legLx[i][9*k +: 9];
               sy[i][k] = legLy[i][9*k +: 9];
               sz[i][k] = legLz[i][9*k +: 9];
               lt = rand_mode ? int'($urandom_range(17, 1)) : lat[k];
               due[i][k]    = never[k] ? -1 : cyc + lt;
               dupdue[i][k] = (dup0 && k == 0 && !never[k]) ? cyc + lt + 1 : -1;
            end
            fire = (cyc == due[i][k]);
            fdup = (cyc == dupdue[i][k]);
            spur = rand_mode && ($urandom_range(24, 0) == 0);
            legDone[i][k] = fire | fdup | spur;
            if (fire) begin
               legL[i][16*k +: 16] = fL(sx[i][k], sy[i][k], sz[i][k]);
               legM[i][15*k +: 15] = fM(sx[i][k], sy[i][k], sz[i][k]);
               legN[i][15*k +: 15] = fN(sx[i][k], sy[i][k], sz[i][k]);
            end else begin
               legL[i][16*k +: 16] = 16'($urandom());
               legM[i][15*k +: 15] = 15'($urandom());
               legN[i][15*k +: 15] = 15'($urandom());
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clock);
      respond();
   endtask

   int w_lv [2], w_lv1 [2], w_lv2 [2], w_vo [2], w_vo1 [2], w_rdy1 [2], w_flt1 [2];

   // Observe n cycles starting from the current one, recording event times.
   task automatic watch(input int n);
      for (int i = 0; i < 2; i++) begin
         w_lv[i] = 0; w_lv1[i] = -1; w_lv2[i] = -1; w_vo[i] = 0;
         w_vo1[i] = -1; w_rdy1[i] = -1; w_flt1[i] = -1;
      end
      for (int j = 0; j < n; j++) begin
         for (int i = 0; i < 2; i++) begin
            if (legValid[i] != 0) begin
               if (w_lv[i] == 0) w_lv1[i] = cyc;
               if (w_lv[i] == 1) w_lv2[i] = cyc;
               w_lv[i]++;
            end
            if (validOut[i]) begin
               if (w_vo[i] == 0) w_vo1[i] = cyc;
               w_vo[i]++;
            end
            if (frameReady[i] && w_rdy1[i] < 0) w_rdy1[i] = cyc;
            if (fault[i] && w_flt1[i] < 0) w_flt1[i] = cyc;
         end
         tick();
      end
   endtask

   task automatic send_frame(input logic [26:0] x, y, z, output int t);
      lxIn = x; lyIn = y; lzIn = z;
      frameValid = 1'b1;
      t = cyc;
      tick();
      frameValid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: actual running required finished");
      $fatal(1);
   end

   initial begin
      int t;
      logic [26:0] x, y, z;
      logic [7:0]  d0;
      reset = 1'b1; frameValid = 1'b0; lxIn = '0; lyIn = '0; lzIn = '0;
      dup0 = 0; rand_mode = 0;
      for (int k = 0; k < 3; k++) begin lat[k] = 5; never[k] = 0; end
      for (int i = 0; i < 2; i++) begin
         legDone[i] = '0; legL[i] = '0; legM[i] = '0; legN[i] = '0;
         for (int k = 0; k < 3; k++) begin due[i][k] = -1; dupdue[i][k] = -1; end
      end
      repeat (3) tick();
      check("rst_frameReady", frameReady[0], 1'b1);
      check("rst_dropCount", dropCount[0], 8'd0);
      reset = 1'b0;
      tick();

      // Directed frame: legs (10,20,30), (-5,7,100), (255,-128,0)
      send_frame({9'h0FF, 9'h1FB, 9'd10}, {9'h180, 9'd7, 9'd20}, {9'd0, 9'd100, 9'd30}, t);
      watch(12);
      check("f1_legValid_once", w_lv[0], 1);
      check("f1_validOut_t7", w_vo1[0], t + 7);
      check("f1_ready_t8", w_rdy1[0], t + 8);
      check("f1_leg0_L", L[0][15:0], 16'hCFA9);
      check("f1_leg2_L", L[0][47:32], 16'h0832);
      repeat (20) tick();

      // Skewed completion: leg 2 three cycles after legs 0/1
      lat[2] = 8;
      send_frame(27'($urandom()), 27'($urandom()), 27'($urandom()), t);
      watch(25);
      check("skew_one_validOut", w_vo[0], 1);
      check("skew_validOut_time", w_vo1[0], t + 10);
      lat[2] = 5;

      // Frames offered while busy are dropped; leg registers hold
      x = 27'($urandom()); y = 27'($urandom()); z = 27'($urandom());
      send_frame(x, y, z, t);
      d0 = dropCount[0];
      lxIn = ~x; lyIn = ~y; lzIn = ~z; frameValid = 1'b1;
      repeat (4) tick();
      frameValid = 1'b0;
      check("drop_four", 8'(dropCount[0] - d0), 8'd4);
      check("drop_legLx_held", legLx[0], x);
      repeat (25) tick();

      // Duplicate legDone[0] must not overwrite the first capture
      lat[0] = 3; lat[1] = 6; lat[2] = 7; dup0 = 1;
      x = 27'($urandom()); y = 27'($urandom()); z = 27'($urandom());
      send_frame(x, y, z, t);
      repeat (20) tick();
      check("dup_leg0_L", L[0][15:0], fL(x[8:0], y[8:0], z[8:0]));
      check("dup_leg0_M", M[1][14:0], fM(x[8:0], y[8:0], z[8:0]));
      dup0 = 0;
      for (int k = 0; k < 3; k++) lat[k] = 5;
      repeat (10) tick();

      // Back-to-back offers: natural period 8 versus MIN_PERIOD 20
      lxIn = 27'($urandom()); frameValid = 1'b1;
      watch(45);
      frameValid = 1'b0;
      check("period_d0", w_lv2[0] - w_lv1[0], 8);
      check("period_d1", w_lv2[1] - w_lv1[1], 20);
      repeat (30) tick();

      // Reset mid-WAIT aborts the frame; late legDone ignored
      send_frame(27'($urandom()), 27'($urandom()), 27'($urandom()), t);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      watch(15);
      check("abort_no_validOut", w_vo[0] + w_vo[1], 0);
      send_frame(27'($urandom()), 27'($urandom()), 27'($urandom()), t);
      watch(12);
      check("after_abort_validOut", w_vo1[0], t + 7);
      repeat (20) tick();

      // Leg 1 hangs: watchdog fault at launch+16
      never[1] = 1;
      send_frame(27'($urandom()), 27'($urandom()), 27'($urandom()), t);
      watch(25);
      check("hang_fault_time", w_flt1[0], t + 17);
      check("hang_no_validOut", w_vo[0], 0);
      d0 = dropCount[0];
      frameValid = 1'b1;
      repeat (3) tick();
      frameValid = 1'b0;
      tick();
      check("fault_not_ready", frameReady[0], 1'b0);
      check("fault_drops", 8'(dropCount[0] - d0), 8'd3);
      never[1] = 0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("post_rst_outputs", {L[0], fault[0], validOut[0], legValid[0], dropCount[0]}, 64'd0);
      check("post_rst_legs", {legLx[0], legLy[0]}, 64'd0);
      check("post_rst_ready", frameReady[0], 1'b1);

      // Randomized traffic, latencies, spurious/duplicate done pulses, resets
      rand_mode = 1;
      for (int j = 0; j < 700; j++) begin
         frameValid = ($urandom_range(2, 0) == 0);
         lxIn = 27'($urandom()); lyIn = 27'($urandom()); lzIn = 27'($urandom());
         reset = ((fault[0] || fault[1]) && $urandom_range(7, 0) == 0) ||
                 ($urandom_range(199, 0) == 0);
         tick();
      end
      reset = 1'b0; frameValid = 1'b0;
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
